keypad_scan_fifo: RTL

Parametrised matrix-keypad front end for the calculator. It drives the keypad columns and samples the rows, debounces over whole scan sweeps, and turns each clean single-key press into a key index. Key indices are queued in a small FIFO behind a valid/ready handshake. It replaces the combinational 8-bit-pattern decoder; translation from key index to calculator symbol stays downstream.

---
 rtl/keypad_scan_fifo_if.sv | 22 ++
 rtl/keypad_scan_fifo.sv | 103 ++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo_if.sv
// keypad_scan_fifo_if: keypad matrix pins plus the key-event valid/ready stream
interface keypad_scan_fifo_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = $clog2(ROWS*COLS)
);
  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;
  logic              any_key;
  logic              overflow;
  modport master (
    input  row_n, key_ready,
    output col_n, key_code, key_valid, any_key, overflow
  );
  modport slave (
    output row_n, key_ready,
    input  col_n, key_code, key_valid, any_key, overflow
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: column scanner, sweep debouncer and single-key event FIFO
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W     = $clog2(ROWS*COLS)
) (
  input logic clk,
  input logic reset,
  keypad_scan_fifo_if.master kp
);
  localparam int N    = ROWS*COLS;
  localparam int CW   = $clog2(COLS);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int SW   = $clog2(DEBOUNCE+1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  logic [ROWS-1:0]   sync1_q, sync2_q;
  logic [CW-1:0]     c_q, c_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [N-1:0]      snap_q, snap_d, prev_q, prev_d, deb_q, deb_d, merged;
  logic [SW-1:0]     stable_q, stable_d;
  logic              push_q, push_d;
  logic [CODE_W-1:0] idx_q, hit_idx;
  logic              sample, sweep_end, same, load, one_hot;
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, full, pop, wr_en, valid;
  // two-flop synchroniser for the asynchronous row inputs; idle level is high
  always_ff @(posedge clk)
    if (reset) {sync2_q, sync1_q} <= '1;
    else {sync2_q, sync1_q} <= {sync1_q, kp.row_n};
  // scan timing, snapshot merge, sweep-to-sweep debounce and press-event detection
  always_comb begin
    sample    = dwell_q == DW'(SCAN_DIV-1);
    sweep_end = sample && c_q == CW'(COLS-1);
    dwell_d   = sample ? '0 : dwell_q + 1'b1;
    c_d       = !sample ? c_q : sweep_end ? '0 : c_q + 1'b1;
    merged    = snap_q;
    merged[c_q*ROWS +: ROWS] = ~sync2_q;
    snap_d    = sample ? merged : snap_q;
    same      = merged == prev_q;
    prev_d    = sweep_end ? merged : prev_q;
    stable_d  = !sweep_end ? stable_q : !same ? '0 : stable_q == SW'(DEBOUNCE) ? stable_q : stable_q + 1'b1;
    load      = sweep_end && same && stable_q == SW'(DEBOUNCE-1);
    deb_d     = load ? merged : deb_q;
    one_hot   = merged != '0 && (merged & (merged - 1'b1)) == '0;
    push_d    = load && one_hot && deb_q == '0;
    hit_idx   = '0;
    for (int i = 0; i < N; i++) if (merged[i]) hit_idx = CODE_W'(i);
  end
  // scan and debounce state; the press event is registered so the push lands one cycle after acceptance
  always_ff @(posedge clk)
    if (reset) begin
      c_q      <= '0;
      dwell_q  <= '0;
      snap_q   <= '0;
      prev_q   <= '0;
      deb_q    <= '0;
      stable_q <= '0;
      push_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      c_q      <= c_d;
      dwell_q  <= dwell_d;
      snap_q   <= snap_d;
      prev_q   <= prev_d;
      deb_q    <= deb_d;
      stable_q <= stable_d;
      push_q   <= push_d;
      idx_q    <= hit_idx;
    end
  // FIFO control: a pop frees the slot so push-when-full-with-pop is still accepted
  always_comb begin
    valid = cnt_q != '0;
    full  = cnt_q == CNTW'(FIFO_DEPTH);
    pop   = valid && kp.key_ready;
    wr_en = push_q && (!full || pop);
    cnt_d = cnt_q + CNTW'(wr_en) - CNTW'(pop);
  end
  // FIFO storage, pointers and sticky overflow flag
  always_ff @(posedge clk)
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_q] <= idx_q;
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
      ovf_q <= ovf_q || (push_q && full && !pop);
    end
  assign kp.col_n     = ~(COLS'(1) << c_q);
  assign kp.key_valid = valid;
  assign kp.key_code  = valid ? mem_q[rd_q] : '0;
  assign kp.any_key   = |deb_q;
  assign kp.overflow  = ovf_q;
endmodule
